// File: rtl/ita_step_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ita_step_sequencer
// Purpose  : Step / head / tile scheduler for the ITA datapath. Latches a
//            layer configuration on start, then walks the step sequence of
//            that layer one tile per datapath tile-completion pulse.
// Revision : 1.0 - initial release
// ============================================================================
module ita_step_sequencer #(
    parameter int H     = 1,
    parameter int TileW = 8,
    parameter int HeadW = (H > 1) ? $clog2(H) : 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [1:0]       layer_i,
    input  logic [TileW-1:0] tile_s_i,
    input  logic [TileW-1:0] tile_e_i,
    input  logic [TileW-1:0] tile_p_i,
    input  logic [TileW-1:0] tile_f_i,
    input  logic             tile_done_i,
    output logic [3:0]       step_o,
    output logic [HeadW-1:0] head_o,
    output logic [TileW-1:0] tile_r_o,
    output logic [TileW-1:0] tile_c_o,
    output logic [TileW-1:0] tile_d_o,
    output logic             first_d_o,
    output logic             last_d_o,
    output logic             busy_o,
    output logic             done_o
);

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_Q      = 4'd1,
        ST_K      = 4'd2,
        ST_V      = 4'd3,
        ST_QK     = 4'd4,
        ST_AV     = 4'd5,
        ST_OW     = 4'd6,
        ST_F1     = 4'd7,
        ST_F2     = 4'd8,
        ST_MATMUL = 4'd9
    } step_t;

    localparam logic [TileW-1:0] c_one       = TileW'(1);
    localparam logic [HeadW-1:0] c_last_head = HeadW'(H - 1);

    step_t            r_step;
    logic [HeadW-1:0] r_head;
    logic [TileW-1:0] r_tile_r, r_tile_c, r_tile_d;
    logic [TileW-1:0] r_cnt_s, r_cnt_e, r_cnt_p, r_cnt_f;
    logic             r_busy;
    logic             r_done;

    // A latched count of zero behaves as a single tile
    logic [TileW-1:0] w_s, w_e, w_p, w_f;
    assign w_s = (r_cnt_s == '0) ? c_one : r_cnt_s;
    assign w_e = (r_cnt_e == '0) ? c_one : r_cnt_e;
    assign w_p = (r_cnt_p == '0) ? c_one : r_cnt_p;
    assign w_f = (r_cnt_f == '0) ? c_one : r_cnt_f;

    // Loop bounds (row, column, depth) of the active step
    logic [TileW-1:0] w_bnd_r, w_bnd_c, w_bnd_d;
    always_comb begin
        w_bnd_r = w_s;
        w_bnd_c = c_one;
        w_bnd_d = c_one;
        case (r_step)
            ST_Q, ST_K, ST_V, ST_MATMUL: begin w_bnd_c = w_p; w_bnd_d = w_e; end
            ST_QK:                       begin w_bnd_c = w_s; w_bnd_d = w_p; end
            ST_AV:                       begin w_bnd_c = w_p; w_bnd_d = w_s; end
            ST_OW:                       begin w_bnd_c = w_e; w_bnd_d = w_p; end
            ST_F1:                       begin w_bnd_c = w_f; w_bnd_d = w_e; end
            ST_F2:                       begin w_bnd_c = w_e; w_bnd_d = w_f; end
            default:                     begin w_bnd_r = c_one; end
        endcase
    end

    logic w_last_r, w_last_c, w_last_d;
    assign w_last_r = (r_tile_r == w_bnd_r - c_one);
    assign w_last_c = (r_tile_c == w_bnd_c - c_one);
    assign w_last_d = (r_tile_d == w_bnd_d - c_one);

    // Successor step once the current step's row loop wraps
    step_t w_next_step;
    logic  w_finish;
    logic  w_head_inc;
    always_comb begin
        w_next_step = ST_IDLE;
        w_finish    = 1'b0;
        w_head_inc  = 1'b0;
        case (r_step)
            ST_Q:  w_next_step = ST_K;
            ST_K:  w_next_step = ST_V;
            ST_V:  w_next_step = ST_QK;
            ST_QK: w_next_step = ST_AV;
            ST_AV: w_next_step = ST_OW;
            ST_OW: begin
                if (r_head == c_last_head) begin
                    w_finish = 1'b1;
                end else begin
                    w_next_step = ST_Q;
                    w_head_inc  = 1'b1;
                end
            end
            ST_F1:     w_next_step = ST_F2;
            ST_F2:     w_finish    = 1'b1;
            ST_MATMUL: w_finish    = 1'b1;
            default:   w_finish    = 1'b0;
        endcase
    end

    // First step of a newly started layer
    step_t w_start_step;
    always_comb begin
        case (layer_i)
            2'd0:    w_start_step = ST_Q;
            2'd1:    w_start_step = ST_F1;
            default: w_start_step = ST_MATMUL;
        endcase
    end

    // Sequencer state: config latch, nested tile counters and step advance
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_step   <= ST_IDLE;
            r_head   <= '0;
            r_tile_r <= '0;
            r_tile_c <= '0;
            r_tile_d <= '0;
            r_cnt_s  <= '0;
            r_cnt_e  <= '0;
            r_cnt_p  <= '0;
            r_cnt_f  <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_step == ST_IDLE) begin
                if (start_i && (layer_i != 2'd3)) begin
                    r_cnt_s  <= tile_s_i;
                    r_cnt_e  <= tile_e_i;
                    r_cnt_p  <= tile_p_i;
                    r_cnt_f  <= tile_f_i;
                    r_step   <= w_start_step;
                    r_head   <= '0;
                    r_tile_r <= '0;
                    r_tile_c <= '0;
                    r_tile_d <= '0;
                    r_busy   <= 1'b1;
                end
            end else if (tile_done_i) begin
                if (!w_last_d) begin
                    r_tile_d <= r_tile_d + c_one;
                end else begin
                    r_tile_d <= '0;
                    if (!w_last_c) begin
                        r_tile_c <= r_tile_c + c_one;
                    end else begin
                        r_tile_c <= '0;
                        if (!w_last_r) begin
                            r_tile_r <= r_tile_r + c_one;
                        end else begin
                            r_tile_r <= '0;
                            if (w_finish) begin
                                r_step <= ST_IDLE;
                                r_head <= '0;
                                r_busy <= 1'b0;
                                r_done <= 1'b1;
                            end else begin
                                r_step <= w_next_step;
                                if (w_head_inc) begin
                                    r_head <= r_head + 1'b1;
                                end
                            end
                        end
                    end
                end
            end
        end
    end

    assign step_o    = r_step;
    assign head_o    = r_head;
    assign tile_r_o  = r_tile_r;
    assign tile_c_o  = r_tile_c;
    assign tile_d_o  = r_tile_d;
    assign busy_o    = r_busy;
    assign done_o    = r_done;
    assign first_d_o = r_busy && (r_tile_d == '0);
    assign last_d_o  = r_busy && w_last_d;

endmodule
`default_nettype wire

// File: tb/tb_ita_step_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ita_step_sequencer
// Purpose  : Self-checking bench for ita_step_sequencer (H=2): vector table,
//            directed multi-cycle sequences and random traffic against a
//            tile-list reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ita_step_sequencer;

    localparam int c_h  = 2;
    localparam int c_tw = 8;
    localparam int c_hw = 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [1:0]      layer;
    logic [c_tw-1:0] ts, te, tp, tf;
    logic            tdone;
    logic [3:0]      step_o;
    logic [c_hw-1:0] head_o;
    logic [c_tw-1:0] tile_r_o, tile_c_o, tile_d_o;
    logic            first_d_o, last_d_o, busy_o, done_o;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ita_step_sequencer #(.H(c_h), .TileW(c_tw)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .layer_i     (layer),
        .tile_s_i    (ts),
        .tile_e_i    (te),
        .tile_p_i    (tp),
        .tile_f_i    (tf),
        .tile_done_i (tdone),
        .step_o      (step_o),
        .head_o      (head_o),
        .tile_r_o    (tile_r_o),
        .tile_c_o    (tile_c_o),
        .tile_d_o    (tile_d_o),
        .first_d_o   (first_d_o),
        .last_d_o    (last_d_o),
        .busy_o      (busy_o),
        .done_o      (done_o)
    );

    // Reference model: the whole layer is expanded into an ordered list of
    // tiles at start; each tile_done pops one entry.
    typedef struct {
        int step;
        int head;
        int r;
        int c;
        int d;
        int dmax;
    } tile_t;

    tile_t mq[$];
    bit    m_done = 1'b0;

    function automatic int nz(input int x);
        return (x == 0) ? 1 : x;
    endfunction

    task automatic push_step(input int st, input int h, input int nr, input int nc, input int nd);
        for (int r = 0; r < nr; r++)
            for (int c = 0; c < nc; c++)
                for (int d = 0; d < nd; d++)
                    mq.push_back('{st, h, r, c, d, nd});
    endtask

    task automatic build(input int ly, input int s0, input int e0, input int p0, input int f0);
        int s, e, p, f;
        s = nz(s0); e = nz(e0); p = nz(p0); f = nz(f0);
        if (ly == 0) begin
            for (int h = 0; h < c_h; h++) begin
                push_step(1, h, s, p, e);
                push_step(2, h, s, p, e);
                push_step(3, h, s, p, e);
                push_step(4, h, s, s, p);
                push_step(5, h, s, p, s);
                push_step(6, h, s, e, p);
            end
        end else if (ly == 1) begin
            push_step(7, 0, s, f, e);
            push_step(8, 0, s, e, f);
        end else begin
            push_step(9, 0, s, p, e);
        end
    endtask

    task automatic model_edge();
        if (rst) begin
            mq.delete();
            m_done = 1'b0;
        end else if (mq.size() != 0) begin
            m_done = 1'b0;
            if (tdone) begin
                void'(mq.pop_front());
                if (mq.size() == 0) m_done = 1'b1;
            end
        end else begin
            m_done = 1'b0;
            if (start && layer != 2'd3) build(int'(layer), int'(ts), int'(te), int'(tp), int'(tf));
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        tile_t t;
        bit    b;
        b = (mq.size() != 0);
        t = b ? mq[0] : '{0, 0, 0, 0, 0, 1};
        check("step",  32'(step_o),    32'(t.step));
        check("head",  32'(head_o),    32'(t.head));
        check("r",     32'(tile_r_o),  32'(t.r));
        check("c",     32'(tile_c_o),  32'(t.c));
        check("d",     32'(tile_d_o),  32'(t.d));
        check("first", 32'(first_d_o), 32'(b && t.d == 0));
        check("last",  32'(last_d_o),  32'(b && t.d == t.dmax - 1));
        check("busy",  32'(busy_o),    32'(b));
        check("done",  32'(done_o),    32'(m_done));
    endtask

    // Apply one cycle of inputs, advance the model on the edge, check after it
    task automatic cycle(input bit r_i, input bit s_i, input int ly, input int s, input int e,
                         input int p, input int f, input bit td);
        rst = r_i; start = s_i; layer = 2'(ly);
        ts = c_tw'(s); te = c_tw'(e); tp = c_tw'(p); tf = c_tw'(f);
        tdone = td;
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    typedef struct {
        int rst, start, layer, s, e, p, f, td;
        int step, r, c, d, first, last, busy, done;
    } vec_t;

    vec_t tbl[12];

    initial begin
        rst = 1'b1; start = 1'b0; layer = 2'd0;
        ts = '0; te = '0; tp = '0; tf = '0; tdone = 1'b0;

        // rst start ly  s  e  p  f td | step r  c  d fst lst bsy dn
        tbl[0]  = '{1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{0, 1, 2, 2, 3, 1, 0, 0,  9, 0, 0, 0, 1, 0, 1, 0};
        tbl[2]  = '{0, 0, 0, 0, 0, 0, 0, 1,  9, 0, 0, 1, 0, 0, 1, 0};
        tbl[3]  = '{0, 0, 0, 0, 0, 0, 0, 1,  9, 0, 0, 2, 0, 1, 1, 0};
        tbl[4]  = '{0, 0, 0, 0, 0, 0, 0, 1,  9, 1, 0, 0, 1, 0, 1, 0};
        tbl[5]  = '{0, 0, 0, 0, 0, 0, 0, 1,  9, 1, 0, 1, 0, 0, 1, 0};
        tbl[6]  = '{0, 0, 0, 0, 0, 0, 0, 1,  9, 1, 0, 2, 0, 1, 1, 0};
        tbl[7]  = '{0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 1};
        tbl[8]  = '{0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0};
        tbl[9]  = '{0, 1, 3, 2, 2, 2, 2, 0,  0, 0, 0, 0, 0, 0, 0, 0};
        tbl[10] = '{0, 1, 2, 1, 0, 1, 0, 0,  9, 0, 0, 0, 1, 1, 1, 0};
        tbl[11] = '{0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0, 1};

        for (int i = 0; i < 12; i++) begin
            cycle(tbl[i].rst[0], tbl[i].start[0], tbl[i].layer, tbl[i].s, tbl[i].e,
                  tbl[i].p, tbl[i].f, tbl[i].td[0]);
            check($sformatf("tbl%0d_step", i),  32'(step_o),    32'(tbl[i].step));
            check($sformatf("tbl%0d_r", i),     32'(tile_r_o),  32'(tbl[i].r));
            check($sformatf("tbl%0d_c", i),     32'(tile_c_o),  32'(tbl[i].c));
            check($sformatf("tbl%0d_d", i),     32'(tile_d_o),  32'(tbl[i].d));
            check($sformatf("tbl%0d_first", i), 32'(first_d_o), 32'(tbl[i].first));
            check($sformatf("tbl%0d_last", i),  32'(last_d_o),  32'(tbl[i].last));
            check($sformatf("tbl%0d_busy", i),  32'(busy_o),    32'(tbl[i].busy));
            check($sformatf("tbl%0d_done", i),  32'(done_o),    32'(tbl[i].done));
        end

        // Attention, H=2, all tiles 1: 12 single-tile steps
        cycle(0, 1, 0, 1, 1, 1, 1, 0);
        for (int i = 0; i < 12; i++) begin
            check("attn_step", 32'(step_o), 32'((i % 6) + 1));
            check("attn_head", 32'(head_o), 32'(i / 6));
            cycle(0, 0, 0, 0, 0, 0, 0, 1);
        end
        check("attn_done", 32'(done_o), 32'd1);

        // Feedforward S=1,E=2,F=3 with a conflicting start mid-run
        cycle(0, 1, 1, 1, 2, 0, 3, 0);
        for (int i = 0; i < 12; i++) begin
            if (i == 4) cycle(0, 1, 2, 5, 5, 5, 5, 0);
            cycle(0, 0, 0, 0, 0, 0, 0, 1);
        end
        // Restart in the done cycle: new config takes effect next cycle
        check("ff_done", 32'(done_o), 32'd1);
        cycle(0, 1, 2, 1, 2, 1, 0, 0);
        check("restart_busy", 32'(busy_o), 32'd1);
        check("restart_step", 32'(step_o), 32'd9);
        cycle(0, 0, 0, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0, 0, 0, 0);

        // Reset while in the QK step
        cycle(0, 1, 0, 1, 1, 1, 1, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 0, 0, 1);
        check("pre_rst_qk", 32'(step_o), 32'd4);
        cycle(1, 0, 0, 0, 0, 0, 0, 1);
        check("rst_no_done", 32'(done_o), 32'd0);
        cycle(0, 0, 0, 0, 0, 0, 0, 0);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) == 0),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), ($urandom_range(0, 1) == 1));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
